// File: rtl/bus_rr_router.sv
// ------------------------------------------------------------------------
// bus_rr_router: round-robin pop/route/push packet switch between terminals
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module bus_rr_router #(
  parameter int              DRVRS     = 4,
  parameter int              PCKG_SZ   = 16,
  parameter int              ID_W      = 8,
  parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
  parameter int              TIMEOUT   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DRVRS-1:0]                  pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]     D_pop,
  output logic [DRVRS-1:0]                  pop,
  input  logic [DRVRS-1:0]                  full,
  output logic [DRVRS-1:0]                  push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]     D_push,
  output logic [15:0]                       drop_cnt,
  output logic                              busy
);

  localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_ROUTE = 2'd2
  } state_t;

  state_t             r_state;
  logic [GW-1:0]      r_last;
  logic [DRVRS-1:0]   r_pop;
  logic [DRVRS-1:0]   r_push;
  logic [PCKG_SZ-1:0] r_hold;
  logic [15:0]        r_drop;
  logic               r_busy;
  logic [TW-1:0]      r_tmo;

  logic               w_found;
  logic [GW-1:0]      w_gnt;
  logic [DRVRS-1:0]   w_gntmask;
  logic [ID_W-1:0]    w_dest;
  logic [DRVRS-1:0]   w_srcmask;
  logic [DRVRS-1:0]   w_mask;
  logic               w_ready;
  logic               w_invalid;

  // Round-robin search starting one past the last granted terminal.
  always_comb begin
    w_found   = 1'b0;
    w_gnt     = '0;
    w_gntmask = '0;
    for (int k = 1; k <= DRVRS; k++) begin
      int idx;
      idx = (int'(r_last) + k) % DRVRS;
      if (!w_found && pndng[idx]) begin
        w_found = 1'b1;
        w_gnt   = GW'(idx);
      end
    end
    w_gntmask[w_gnt] = 1'b1;
  end

  // During POP the packet is still on D_pop, so the route decision looks
  // there directly; afterwards it looks at the held copy. last_grant is the
  // source terminal for the whole transfer.
  always_comb begin
    w_dest = (r_state == S_POP) ? D_pop[r_last][PCKG_SZ-1 -: ID_W]
                                : r_hold[PCKG_SZ-1 -: ID_W];
    w_srcmask         = '0;
    w_srcmask[r_last] = 1'b1;
    w_mask    = '0;
    w_ready   = 1'b0;
    w_invalid = 1'b0;
    if (w_dest == BROADCAST) begin
      w_mask  = ~w_srcmask;
      w_ready = ((full & w_mask) == '0);
    end else if ((int'(w_dest) < DRVRS) && (int'(w_dest) != int'(r_last))) begin
      w_mask[w_dest[GW-1:0]] = 1'b1;
      w_ready                = !full[w_dest[GW-1:0]];
    end else begin
      w_invalid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_last  <= GW'(DRVRS - 1);
      r_pop   <= '0;
      r_push  <= '0;
      r_hold  <= '0;
      r_drop  <= '0;
      r_busy  <= 1'b0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last  <= w_gnt;
            r_pop   <= w_gntmask;
            r_busy  <= 1'b1;
            r_state <= S_POP;
          end
        end
        S_POP: begin
          r_pop   <= '0;
          r_hold  <= D_pop[r_last];
          r_tmo   <= TW'(1);
          r_state <= S_ROUTE;
          if (w_ready) r_push <= w_mask;
        end
        S_ROUTE: begin
          if (r_push != '0) begin
            r_push  <= '0;
            r_tmo   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_invalid || (!w_ready && (r_tmo == TW'(TIMEOUT)))) begin
            r_drop  <= (r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1;
            r_tmo   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_ready) begin
            r_push <= w_mask;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar i = 0; i < DRVRS; i++) begin : g_dpush
      assign D_push[i] = r_hold;
    end
  endgenerate

  assign pop      = r_pop;
  assign push     = r_push;
  assign drop_cnt = r_drop;
  assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_router.sv
// ------------------------------------------------------------------------
// tb_bus_rr_router: directed self-checking bench for bus_rr_router
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_bus_rr_router;

  logic              clk;
  logic              reset;
  logic [3:0]        pndng;
  logic [3:0][15:0]  D_pop;
  logic [3:0]        pop;
  logic [3:0]        full;
  logic [3:0]        push;
  logic [3:0][15:0]  D_push;
  logic [15:0]       drop_cnt;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  bus_rr_router #(
    .DRVRS    (4),
    .PCKG_SZ  (16),
    .ID_W     (8),
    .BROADCAST(8'hFF),
    .TIMEOUT  (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .full    (full),
    .push    (push),
    .D_push  (D_push),
    .drop_cnt(drop_cnt),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    pndng = '0;
    full  = '0;
    D_pop = '0;
    #2;
    check("rst_pop",  64'(pop), 64'h0);
    check("rst_push", 64'(push), 64'h0);
    check("rst_dpush", 64'(D_push[0]), 64'h0);
    check("rst_drop", 64'(drop_cnt), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    tick();
    tick();
    reset = 1'b1;

    // Unicast 1 -> 2
    pndng    = 4'b0010;
    D_pop[1] = 16'h02AB;
    tick();
    check("uni_pop",  64'(pop), 64'h2);
    check("uni_busy", 64'(busy), 64'h1);
    pndng = '0;
    tick();
    check("uni_push",  64'(push), 64'h4);
    check("uni_dpush", 64'(D_push[2]), 64'h02AB);
    check("uni_pop0",  64'(pop), 64'h0);
    tick();
    check("uni_idle_push", 64'(push), 64'h0);
    check("uni_idle_busy", 64'(busy), 64'h0);
    check("uni_drop", 64'(drop_cnt), 64'h0);

    // Broadcast from 3
    pndng    = 4'b1000;
    D_pop[3] = 16'hFF55;
    tick();
    check("bc_pop", 64'(pop), 64'h8);
    pndng = '0;
    tick();
    check("bc_push", 64'(push), 64'h7);
    check("bc_d0", 64'(D_push[0]), 64'hFF55);
    check("bc_d1", 64'(D_push[1]), 64'hFF55);
    check("bc_d2", 64'(D_push[2]), 64'hFF55);
    tick();
    check("bc_done", 64'(push), 64'h0);

    // Backpressure: 2 -> 0 with full[0] high for 5 cycles
    pndng    = 4'b0100;
    D_pop[2] = 16'h0077;
    full     = 4'b0001;
    tick();
    check("bp_pop", 64'(pop), 64'h4);
    pndng = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_wait_push", 64'(push), 64'h0);
      check("bp_wait_busy", 64'(busy), 64'h1);
    end
    full = '0;
    tick();
    check("bp_push",  64'(push), 64'h1);
    check("bp_dpush", 64'(D_push[0]), 64'h0077);
    tick();
    check("bp_idle", 64'(busy), 64'h0);

    // Timeout: full[0] held high
    pndng = 4'b0100;
    full  = 4'b0001;
    tick();
    check("to_pop", 64'(pop), 64'h4);
    pndng = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("to_wait_busy", 64'(busy), 64'h1);
      check("to_wait_push", 64'(push), 64'h0);
      check("to_wait_drop", 64'(drop_cnt), 64'h0);
    end
    tick();
    check("to_drop", 64'(drop_cnt), 64'h1);
    check("to_idle", 64'(busy), 64'h0);
    full = '0;

    // Invalid destination 5 from terminal 0
    pndng    = 4'b0001;
    D_pop[0] = 16'h0500;
    tick();
    check("inv5_pop", 64'(pop), 64'h1);
    pndng = '0;
    tick();
    check("inv5_push", 64'(push), 64'h0);
    check("inv5_busy", 64'(busy), 64'h1);
    tick();
    check("inv5_idle", 64'(busy), 64'h0);
    check("inv5_drop", 64'(drop_cnt), 64'h2);

    // Invalid destination == source (terminal 1)
    pndng    = 4'b0010;
    D_pop[1] = 16'h0100;
    tick();
    check("self_pop", 64'(pop), 64'h2);
    pndng = '0;
    tick();
    check("self_push", 64'(push), 64'h0);
    tick();
    check("self_idle", 64'(busy), 64'h0);
    check("self_drop", 64'(drop_cnt), 64'h3);

    // Reset while stalled in ROUTE
    pndng    = 4'b0100;
    D_pop[2] = 16'h0099;
    full     = 4'b0001;
    tick();
    check("rm_pop", 64'(pop), 64'h4);
    pndng = '0;
    tick();
    tick();
    check("rm_busy_pre", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    check("rm_busy",  64'(busy), 64'h0);
    check("rm_push",  64'(push), 64'h0);
    check("rm_pop0",  64'(pop), 64'h0);
    check("rm_dpush", 64'(D_push[0]), 64'h0);
    check("rm_drop",  64'(drop_cnt), 64'h0);
    reset = 1'b1;
    full  = '0;

    // Round robin with every terminal pending: 0,1,2,3,0, dest = src+1
    D_pop[0] = 16'h0100;
    D_pop[1] = 16'h0211;
    D_pop[2] = 16'h0322;
    D_pop[3] = 16'h0033;
    pndng    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      int d;
      g = k % 4;
      d = (g + 1) % 4;
      tick();
      check("rr_pop", 64'(pop), 64'(1 << g));
      tick();
      check("rr_push",  64'(push), 64'(1 << d));
      check("rr_dpush", 64'(D_push[d]), 64'(D_pop[g]));
      tick();
      check("rr_gap", 64'({pop, push}), 64'h0);
    end
    pndng = '0;
    check("rr_drop", 64'(drop_cnt), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
